// File: rtl/imm_gen_pkg.sv
// Shared constants and the immediate-extraction function for the pipelined imm generator.
// The function always builds a 64-bit result; callers cast it down to their XLEN.
package imm_gen_pkg;

   localparam logic [2:0] EXTOP_NONE   = 3'b000;
   localparam logic [2:0] EXTOP_STYPE  = 3'b001;
   localparam logic [2:0] EXTOP_ITYPE  = 3'b010;
   localparam logic [2:0] EXTOP_ISHAMT = 3'b011;
   localparam logic [2:0] EXTOP_BTYPE  = 3'b100;
   localparam logic [2:0] EXTOP_UTYPE  = 3'b101;
   localparam logic [2:0] EXTOP_JTYPE  = 3'b110;

   typedef enum logic [1:0] {SB_EMPTY, SB_ONE, SB_FULL} sb_state_t;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

   // Returns {illegal, imm[63:0]}; truncation to 32 bits keeps sign extension correct.
   function automatic logic [64:0] ext_imm(input logic [31:0] instr, input logic [2:0] extop,
                                           input logic is64);
      logic [63:0] imm;
      logic        ill;
      imm = '0;
      ill = 1'b0;
      case (extop)
         EXTOP_NONE:   imm = '0;
         EXTOP_STYPE:  imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         EXTOP_ITYPE:  imm = {{52{instr[31]}}, instr[31:20]};
         EXTOP_ISHAMT: imm = is64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
         EXTOP_BTYPE:  imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         EXTOP_UTYPE:  imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         EXTOP_JTYPE:  imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:      ill = 1'b1;
      endcase
      return {ill, imm};
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side request and ID/EX-side response handshake of the immediate generator.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [2:0]       in_extop;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_extop, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_extop, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry FIFO skid buffer; in_ready is registered so downstream stalls never reach upstream
// combinationally. Output payload reads zero whenever no entry is valid.
module imm_skid_buf
   import imm_gen_pkg::*;
#(
   parameter int W = 38
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   sb_state_t    state_q, state_d;
   logic [W-1:0] head_q, tail_q;
   logic         rdy_q;
   logic         push, pop;

   assign push = in_valid && rdy_q;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= SB_EMPTY;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != SB_FULL);
      end
   end

   // Flush overrides any concurrent accept or pop.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = SB_EMPTY;
      end else begin
         case (state_q)
            SB_EMPTY: if (push) state_d = SB_ONE;
            SB_ONE: begin
               if (push && !pop)      state_d = SB_FULL;
               else if (!push && pop) state_d = SB_EMPTY;
            end
            SB_FULL:  if (pop) state_d = SB_ONE;
            default:  state_d = SB_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid = (state_q != SB_EMPTY);
      out_data  = out_valid ? head_q : '0;
      in_ready  = rdy_q;
   end

   // Head is what the consumer sees; tail only fills while the head is stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (!flush) begin
         case (state_q)
            SB_EMPTY: if (push) head_q <= in_data;
            SB_ONE: begin
               if (push && pop) head_q <= in_data;
               else if (push)   tail_q <= in_data;
            end
            SB_FULL:  if (pop) head_q <= tail_q;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate extender: extends on the input side, then buffers {illegal, imm, tag}
// in a 2-entry skid buffer so every output comes straight from a register.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   imm_gen_pipe_if.slave bus
);

   localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
   localparam int PW      = XLEN + TAG_W + 1;

   generate
      if (!xlen_legal(XLEN)) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   logic [64:0]     ext;
   logic [63:0]     imm64;
   logic [XLEN-1:0] imm;
   logic [PW-1:0]   in_pl, out_pl;

   assign ext   = ext_imm(bus.in_instr, bus.in_extop, SHAMT_W == 6);
   assign imm64 = ext[63:0];
   assign imm   = XLEN'(imm64);
   assign in_pl = {ext[64], imm, bus.in_tag};

   imm_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_pl),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_pl)
   );

   assign {bus.out_illegal, bus.out_imm, bus.out_tag} = out_pl;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance sharing clock/reset/flush.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic flush;
   int   checks = 0;
   int   failures = 0;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (.clk(clk), .rstn(rstn), .flush(flush), .bus(b32));
   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (.clk(clk), .rstn(rstn), .flush(flush), .bus(b64));

   always #5 clk = ~clk;

   task automatic drv32(input logic v, input logic [31:0] i, input logic [2:0] op, input logic [4:0] t);
      b32.in_valid = v; b32.in_instr = i; b32.in_extop = op; b32.in_tag = t;
   endtask

   task automatic drv64(input logic v, input logic [31:0] i, input logic [2:0] op, input logic [4:0] t);
      b64.in_valid = v; b64.in_instr = i; b64.in_extop = op; b64.in_tag = t;
   endtask

   task automatic test_reset;
      rstn = 1'b0; flush = 1'b0;
      drv32(0, 32'h0, 3'b0, 5'd0); drv64(0, 32'h0, 3'b0, 5'd0);
      b32.out_ready = 1'b1; b64.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b32.out_valid); end
      checks++; if (b32.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", b32.in_ready); end
      checks++; if (b32.out_imm !== 32'h0) begin failures++; $display("FAIL reset_imm got=%h exp=0", b32.out_imm); end
      checks++; if (b32.out_tag !== 5'd0 || b32.out_illegal !== 1'b0) begin failures++; $display("FAIL reset_tag_ill got=%0d/%b exp=0/0", b32.out_tag, b32.out_illegal); end
      checks++; if (b64.out_valid !== 1'b0 || b64.out_imm !== 64'h0) begin failures++; $display("FAIL reset64 got=%b/%h exp=0/0", b64.out_valid, b64.out_imm); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_itype;
      drv32(1, 32'hFFF00093, EXTOP_ITYPE, 5'd1);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL itype got=%b/%h exp=1/ffffffff", b32.out_valid, b32.out_imm); end
      checks++; if (b32.out_tag !== 5'd1 || b32.out_illegal !== 1'b0) begin failures++; $display("FAIL itype_tag got=%0d/%b exp=1/0", b32.out_tag, b32.out_illegal); end
      drv32(1, 32'h03F09093, EXTOP_ISHAMT, 5'd2);
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'h1F) begin failures++; $display("FAIL shamt32 got=%h exp=0000001f", b32.out_imm); end
      drv32(0, 32'h0, 3'b0, 5'd0);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0 || b32.out_imm !== 32'h0 || b32.out_tag !== 5'd0) begin failures++; $display("FAIL drain_zero got=%b/%h/%0d exp=0/0/0", b32.out_valid, b32.out_imm, b32.out_tag); end
   endtask

   task automatic test_back_to_back;
      drv32(1, 32'hFE112E23, EXTOP_STYPE, 5'd2);
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'hFFFFFFFC || b32.out_tag !== 5'd2) begin failures++; $display("FAIL stype got=%h/%0d exp=fffffffc/2", b32.out_imm, b32.out_tag); end
      drv32(1, 32'hFE000CE3, EXTOP_BTYPE, 5'd3);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFF8 || b32.out_tag !== 5'd3) begin failures++; $display("FAIL btype got=%b/%h/%0d exp=1/fffffff8/3", b32.out_valid, b32.out_imm, b32.out_tag); end
      drv32(0, 32'h0, 3'b0, 5'd0);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", b32.out_valid); end
   endtask

   task automatic test_xlen64;
      drv64(1, 32'h123452B7, EXTOP_UTYPE, 5'd4);
      @(negedge clk);
      checks++; if (b64.out_imm !== 64'h0000000012345000) begin failures++; $display("FAIL utype64 got=%h exp=0000000012345000", b64.out_imm); end
      drv64(1, 32'hFFDFF06F, EXTOP_JTYPE, 5'd5);
      @(negedge clk);
      checks++; if (b64.out_imm !== 64'hFFFFFFFFFFFFFFFC || b64.out_tag !== 5'd5) begin failures++; $display("FAIL jtype64 got=%h/%0d exp=fffffffffffffffc/5", b64.out_imm, b64.out_tag); end
      drv64(1, 32'h03F09093, EXTOP_ISHAMT, 5'd6);
      @(negedge clk);
      checks++; if (b64.out_imm !== 64'h3F) begin failures++; $display("FAIL shamt64 got=%h exp=3f", b64.out_imm); end
      drv64(1, 32'h800002B7, EXTOP_UTYPE, 5'd7);
      @(negedge clk);
      checks++; if (b64.out_imm !== 64'hFFFFFFFF80000000) begin failures++; $display("FAIL utype64_neg got=%h exp=ffffffff80000000", b64.out_imm); end
      drv64(0, 32'h0, 3'b0, 5'd0);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      b32.out_ready = 1'b0;
      drv32(1, 32'h00100093, EXTOP_ITYPE, 5'd4);
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'h1 || b32.in_ready !== 1'b1) begin failures++; $display("FAIL bp_first got=%h/%b exp=1/1", b32.out_imm, b32.in_ready); end
      drv32(1, 32'h00200093, EXTOP_ITYPE, 5'd5);
      @(negedge clk);
      checks++; if (b32.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", b32.in_ready); end
      drv32(1, 32'h00300093, EXTOP_ITYPE, 5'd6);
      for (int k = 0; k < 3; k++) begin
         checks++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h1 || b32.out_tag !== 5'd4) begin failures++; $display("FAIL bp_stable cyc=%0d got=%b/%h/%0d exp=1/1/4", k, b32.out_valid, b32.out_imm, b32.out_tag); end
         @(negedge clk);
      end
      b32.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'h2 || b32.out_tag !== 5'd5 || b32.in_ready !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%0d/%b exp=2/5/1", b32.out_imm, b32.out_tag, b32.in_ready); end
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'h3 || b32.out_tag !== 5'd6) begin failures++; $display("FAIL bp_third got=%h/%0d exp=3/6", b32.out_imm, b32.out_tag); end
      drv32(0, 32'h0, 3'b0, 5'd0);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", b32.out_valid); end
   endtask

   task automatic test_flush_illegal;
      b32.out_ready = 1'b0;
      drv32(1, 32'h00700093, EXTOP_ITYPE, 5'd7); @(negedge clk);
      drv32(1, 32'h00800093, EXTOP_ITYPE, 5'd8); @(negedge clk);
      checks++; if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin failures++; $display("FAIL fl_full got=%b/%b exp=0/1", b32.in_ready, b32.out_valid); end
      flush = 1'b1; drv32(1, 32'h00900093, EXTOP_ITYPE, 5'd9);
      @(negedge clk);
      flush = 1'b0; drv32(0, 32'h0, 3'b0, 5'd0); b32.out_ready = 1'b1;
      checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.out_imm !== 32'h0) begin failures++; $display("FAIL fl_full_empty got=%b/%b/%h exp=0/1/0", b32.out_valid, b32.in_ready, b32.out_imm); end
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL fl_no_emit got=%b exp=0", b32.out_valid); end
      // flush from ONE while an accept is offered: the accept is dropped too
      b32.out_ready = 1'b0;
      drv32(1, 32'h00A00093, EXTOP_ITYPE, 5'd10); @(negedge clk);
      flush = 1'b1; drv32(1, 32'h00B00093, EXTOP_ITYPE, 5'd11);
      @(negedge clk);
      flush = 1'b0; drv32(0, 32'h0, 3'b0, 5'd0); b32.out_ready = 1'b1;
      checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin failures++; $display("FAIL fl_accept_drop got=%b/%b exp=0/1", b32.out_valid, b32.in_ready); end
      @(negedge clk);
      drv32(1, 32'hFFFFFFFF, 3'b111, 5'd9);
      @(negedge clk);
      checks++; if (b32.out_imm !== 32'h0 || b32.out_illegal !== 1'b1 || b32.out_tag !== 5'd9) begin failures++; $display("FAIL illegal got=%h/%b/%0d exp=0/1/9", b32.out_imm, b32.out_illegal, b32.out_tag); end
      drv32(1, 32'hFFFFFFFF, EXTOP_NONE, 5'd3);
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h0 || b32.out_illegal !== 1'b0) begin failures++; $display("FAIL none got=%b/%h/%b exp=1/0/0", b32.out_valid, b32.out_imm, b32.out_illegal); end
      drv32(0, 32'h0, 3'b0, 5'd0);
      @(negedge clk);
   endtask

   task automatic test_reset_midstream;
      b32.out_ready = 1'b0;
      drv32(1, 32'h00100093, EXTOP_ITYPE, 5'd1); @(negedge clk);
      drv32(1, 32'h00200093, EXTOP_ITYPE, 5'd2); @(negedge clk);
      drv32(0, 32'h0, 3'b0, 5'd0);
      checks++; if (b32.in_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_full got=%b exp=0", b32.in_ready); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.out_imm !== 32'h0) begin failures++; $display("FAIL rst_async got=%b/%b/%h exp=0/1/0", b32.out_valid, b32.in_ready, b32.out_imm); end
      @(negedge clk);
      rstn = 1'b1; b32.out_ready = 1'b1;
      @(negedge clk);
      drv32(1, 32'hFFF00093, EXTOP_ITYPE, 5'd10);
      @(negedge clk);
      drv32(0, 32'h0, 3'b0, 5'd0);
      checks++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFFF || b32.out_tag !== 5'd10) begin failures++; $display("FAIL rst_fresh got=%b/%h/%0d exp=1/ffffffff/10", b32.out_valid, b32.out_imm, b32.out_tag); end
      @(negedge clk);
      checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL rst_fresh_drain got=%b exp=0", b32.out_valid); end
   endtask

   initial begin
      test_reset();
      test_itype();
      test_back_to_back();
      test_xlen64();
      test_backpressure();
      test_flush_illegal();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender in the decode path.
- Takes the raw 32-bit instruction word and an extension opcode, and extracts the immediate fields internally.
- Produces an XLEN-wide sign- or zero-extended immediate, covering I, I-shamt, S, B, U and J formats.
- Sits between decode and the ID/EX register behind a valid/ready handshake, with a 2-entry skid buffer so back-pressure never creates a combinational ready path.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount width taken from instr[20+:SHAMT_W]; derived, do not override.
- TAG_W, 5, width of the opaque sideband tag (e.g. rd index or ROB id) carried alongside the data.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered, equals !full.
- in_instr  in  32  raw instruction word.
- in_extop  in  3  extension opcode (see Behaviour).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the head entry.
- out_illegal  out  1  head entry had an undefined in_extop.

Behaviour:
- Reset (rstn=0, asynchronous): both entries invalid; out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- EXTOp encoding (package constants):
  - NONE=000 gives 0.
  - STYPE=001: sext({instr[31:25],instr[11:7]}).
  - ITYPE=010: sext(instr[31:20]).
  - ISHAMT=011: zext(instr[20+:SHAMT_W]).
  - BTYPE=100: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - UTYPE=101: sext({instr[31:12],12'b0}); upper bits replicate instr[31] when XLEN=64.
  - JTYPE=110: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 111 is undefined: imm=0, illegal=1.
  - All sign extension replicates the top field bit to XLEN.
- Extension is combinational on the input side. The result, tag and illegal bit are written into the buffer on accept (in_valid && in_ready).
- Latency: 1 cycle. An entry accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty.
- Buffer: 2 entries, FIFO order, occupancy count 0..2.
  - States EMPTY (count 0), ONE (1), FULL (2).
  - EMPTY: accept goes to ONE.
  - ONE: accept with no pop goes to FULL; pop with no accept goes to EMPTY; accept and pop together stays in ONE, with the new entry becoming head.
  - FULL: pop goes to ONE; no accept is possible because in_ready=0.
- Pop occurs on out_valid && out_ready.
- in_ready is a register equal to (count<2). It does not depend combinationally on out_ready.
- out_* are driven from the head entry register, so there is no combinational in-to-out path.
- While out_valid=1 && out_ready=0, out_imm, out_tag and out_illegal must hold stable.
- flush: the next state is EMPTY and in_ready becomes 1.
  - Any accept in the same cycle is discarded.
  - Flush has priority over accept and pop.
- Reset asserted mid-operation: immediate return to the reset values. No entry survives.
- When out_valid=0, out_imm, out_tag and out_illegal read 0, never stale data.

Decomposition:
- Package imm_gen_pkg holds:
  - EXTOP_* 3-bit localparams (values above);
  - the XLEN legality check;
  - a function ext_imm(instr, extop) returning {illegal, imm}.
- Sub-module imm_skid_buf: the 2-entry valid/ready skid buffer, parametrised on payload width XLEN+TAG_W+1. imm_gen_pipe instantiates one.

Test Plan (XLEN=32 unless stated):
- I: in_instr=0xFFF00093, ITYPE, tag=1 -> next cycle out_imm=0xFFFFFFFF, out_tag=1, out_illegal=0.
- S/B: 0xFE112E23 STYPE -> 0xFFFFFFFC; then 0xFE000CE3 BTYPE back-to-back -> 0xFFFFFFF8 on the following cycle.
- U/J at XLEN=64:
  - 0x123452B7 UTYPE -> 0x0000000012345000.
  - 0xFFDFF06F JTYPE -> 0xFFFFFFFFFFFFFFFC.
  - 0x03F09093 ISHAMT -> 0x3F.
- Back-pressure: hold out_ready=0 and push 3 instructions -> the first two are accepted, in_ready=0 after the second, and out_imm stays stable. Release out_ready -> outputs come in order with no loss or duplication.
- flush/illegal:
  - With count=2, assert flush together with in_valid -> out_valid=0 and in_ready=1 next cycle; nothing is emitted.
  - extop=111 -> out_imm=0, out_illegal=1.
- Reset mid-stream: drop rstn asynchronously while FULL -> out_valid=0 and in_ready=1 immediately. After release, a fresh 0xFFF00093/ITYPE yields 0xFFFFFFFF.
